shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Multi-cycle controller that sits directly upstream of the single-step 16-bit shifter and also consumes its output.
- Accepts an operand, a shift op and a count, then drives the shifter once per cycle, feeding its Y/C_out back as the next A/C_in.
- Presents the final result and carry to the register-writeback/flag stage with a start/busy/done handshake.
- Gives the datapath N-bit shifts from a 1-bit shifter.

Parameters:
- WIDTH, 16, datapath width; must match the shifter.
- CNT_W, 4, count width; shift counts run 0..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  shift op: 00 none, 01 ROR, 10 ASR, 11 RRC.
- count  input  CNT_W  number of single-bit steps.
- operand  input  WIDTH  value to shift.
- carry_in  input  1  initial carry (used by RRC).
- busy  output  1  high while a request is in progress (state != IDLE).
- done  output  1  one-cycle pulse; result/carry_out valid.
- result  output  WIDTH  final shifted value; held until next accepted start.
- carry_out  output  1  final carry; held with result.
- sh_a  output  WIDTH  to shifter A (accumulator).
- sh_op  output  2  to shifter op; latched op in SHIFT, 00 otherwise.
- sh_cin  output  1  to shifter C_in (carry register).
- sh_y  input  WIDTH  from shifter Y.
- sh_cout  input  1  from shifter C_out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Accumulator, result, carry register and carry_out = 0.
  - busy=0, done=0, remaining count=0.
  - Reset asserted mid-operation aborts it; no done pulse is issued.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at an edge:
  - Latch acc<=operand, c<=carry_in, op_r<=op, rem<=count.
  - If count==0 or op==00, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, each edge:
  - acc<=sh_y, c<=sh_cout, rem<=rem-1.
  - When rem==1 at the edge, go to DONE.
  - Exactly count shifter steps are applied.
  - Shifter path is combinational within the cycle: sh_a=acc, sh_cin=c, sh_op=op_r.
- DONE, one cycle:
  - done=1, result=acc, carry_out=c (registered, stable from this cycle).
  - Next edge goes to IDLE.
- Latency: done is asserted count+1 cycles after the start edge for count>=1, and 1 cycle after for count==0 or op==00.
- No-op (op==00): result=operand, carry_out=carry_in.
- Handshake:
  - start is ignored in SHIFT and DONE; no queuing.
  - Back-to-back requests: start may be asserted in the cycle after done (IDLE).
- Carry: taken as sh_cout every step for ops 01/10/11, i.e. the last bit shifted out.
- rem never underflows; wrap is impossible because SHIFT is never entered with rem==0.
- The operand is not re-read after acceptance; input changes during busy have no effect.
- result and carry_out change only on entry to DONE or on reset.

Decomposition:
- Shared package/include:
  - Op encodings: SH_NONE=2'b00, SH_ROR=2'b01, SH_ASR=2'b10, SH_RRC=2'b11.
  - State encodings: IDLE, SHIFT, DONE.
  - WIDTH and CNT_W defaults.
- One sub-module, shift_count: CNT_W-bit loadable down-counter with load, dec and a last (==1) flag.
- The shifter itself is instantiated by the parent datapath, not inside this block. The bench instantiates shifter plus sequencer.

Test Plan:
- ROR: operand=0x1234, count=4, op=01, carry_in=0 -> done 5 cycles after start; result=0x4123, carry_out=0; busy high 5 cycles.
- ASR: operand=0x8014, count=3, op=10 -> result=0xF002, carry_out=1; done 4 cycles after start.
- RRC: operand=0x0001, count=2, op=11, carry_in=0 -> step1 acc=0x0000 c=1, step2 acc=0x8000 c=0; result=0x8000, carry_out=0.
- count=0, operand=0xBEEF, carry_in=1, op=01 -> done 1 cycle after start; result=0xBEEF, carry_out=1; sh_op stays 00 throughout.
- Second start pulse with operand=0xFFFF issued mid-SHIFT of the first request -> ignored; first result unaffected; exactly one done.
- rst_n pulled low during SHIFT (count=10, third step) -> busy=0, done=0, result=0x0000, carry_out=0 immediately; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings and default widths for the multi-cycle shift sequencer
// and the single-step shifter it drives.
package shift_sequencer_pkg;

  localparam int SS_WIDTH = 16;
  localparam int SS_CNT_W = 4;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_ROR  = 2'b01,
    SH_ASR  = 2'b10,
    SH_RRC  = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response handshake plus the loop to the external single-step shifter.
interface shift_sequencer_if #(
  parameter int WIDTH = shift_sequencer_pkg::SS_WIDTH,
  parameter int CNT_W = shift_sequencer_pkg::SS_CNT_W
);

  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] operand;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic [WIDTH-1:0] sh_a;
  logic [1:0]       sh_op;
  logic             sh_cin;
  logic [WIDTH-1:0] sh_y;
  logic             sh_cout;

  // master: requester plus shifter side; slave: the sequencer itself
  modport master (
    output start, op, count, operand, carry_in, sh_y, sh_cout,
    input  busy, done, result, carry_out, sh_a, sh_op, sh_cin
  );

  modport slave (
    input  start, op, count, operand, carry_in, sh_y, sh_cout,
    output busy, done, result, carry_out, sh_a, sh_op, sh_cin
  );

endinterface

// File: rtl/shift_sequencer_count.sv
// Loadable down-counter tracking remaining shift steps; last flags the final step.
module shift_sequencer_count #(
  parameter int CNT_W = shift_sequencer_pkg::SS_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at zero so a stray dec can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle controller turning a 1-bit shifter into an N-bit shifter by
// looping its Y/C_out back into A/C_in once per cycle.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = SS_WIDTH,
  parameter int CNT_W = SS_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_sequencer_if.slave    bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       sh_op_q, sh_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_dec, cnt_last;

  shift_sequencer_count #(.CNT_W(CNT_W)) u_count (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (bus.count),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // Outputs are computed from the next state so they are registered yet
  // line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    c_d         = c_q;
    op_d        = op_q;
    sh_op_d     = SH_NONE;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    done_d      = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d    = bus.operand;
          c_d      = bus.carry_in;
          op_d     = bus.op;
          cnt_load = 1'b1;
          if ((bus.count == '0) || (bus.op == SH_NONE)) begin
            state_d     = DONE;
            result_d    = bus.operand;
            carry_out_d = bus.carry_in;
            done_d      = 1'b1;
          end else begin
            state_d = SHIFT;
            sh_op_d = bus.op;
          end
        end
      end
      SHIFT: begin
        acc_d   = bus.sh_y;
        c_d     = bus.sh_cout;
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d     = DONE;
          result_d    = bus.sh_y;
          carry_out_d = bus.sh_cout;
          done_d      = 1'b1;
        end else begin
          sh_op_d = op_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      c_q         <= 1'b0;
      op_q        <= SH_NONE;
      sh_op_q     <= SH_NONE;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      op_q        <= op_d;
      sh_op_q     <= sh_op_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.sh_a      = acc_q;
  assign bus.sh_cin    = c_q;
  assign bus.sh_op     = sh_op_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
